// File: rtl/csa42_accum.sv
// Carry-save 4:2 accumulator: folds operand pairs into registered S/C vectors and
// resolves S+C with a CPA at the end of each group. Optional macro: CSA42_SPLIT_RESOLVE_EN.
module csa42_accum #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt
);

  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] RESOLVE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] c_reg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             start;
  logic [WIDTH-1:0] s_in, c_in, t, cout, cin, carry, s_next, c_next;
  logic [CNT_W-1:0] cnt_next;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  // A zero counter only occurs after reset or a handshake, so that beat starts a group.
  assign start = in_first | (cnt == '0);

  // Compressor row; lateral carry comes from the neighbour's majority, so no ripple.
  assign s_in   = start ? '0 : s_reg;
  assign c_in   = start ? '0 : c_reg;
  assign t      = in_a ^ in_b ^ s_in ^ c_in;
  assign cout   = (in_a & in_b) | (in_a & s_in) | (in_b & s_in);
  assign cin    = {cout[WIDTH-2:0], 1'b0};
  assign s_next = t ^ cin;
  assign carry  = (c_in & ~t) | (cin & t);
  assign c_next = {carry[WIDTH-2:0], 1'b0};

  assign cnt_next = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));

`ifdef CSA42_SPLIT_RESOLVE_EN
  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;
  logic phase;
  logic lo_carry;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s_reg     <= '0;
      c_reg     <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
`ifdef CSA42_SPLIT_RESOLVE_EN
      phase     <= 1'b0;
      lo_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s_reg <= s_next;
            c_reg <= c_next;
            cnt   <= cnt_next;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
`ifdef CSA42_SPLIT_RESOLVE_EN
          if (!phase) begin
            {lo_carry, out_sum[LO_W-1:0]} <= {1'b0, s_reg[LO_W-1:0]} + {1'b0, c_reg[LO_W-1:0]};
            phase <= 1'b1;
          end else begin
            out_sum[WIDTH-1:LO_W] <= s_reg[WIDTH-1:LO_W] + c_reg[WIDTH-1:LO_W] + HI_W'(lo_carry);
            out_cnt <= cnt;
            phase   <= 1'b0;
            state   <= DONE;
          end
`else
          out_sum <= s_reg + c_reg;
          out_cnt <= cnt;
          state   <= DONE;
`endif
        end
        DONE: begin
          // The result register settles one cycle before it is offered downstream.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            s_reg     <= '0;
            c_reg     <= '0;
            cnt       <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
